// File: rtl/des_pkg.sv
// =============================================================================
// des_pkg : shared DES constants (IP/FP tables, stage defaults, occupancy)
// Revision: 1.0
// =============================================================================
`default_nettype none

package des_pkg;

    localparam int c_CNT_W_DEFAULT = 16;
    localparam int c_FIFO_DEPTH    = 2;

    // DES bit numbering (1 = MSB); entry k is the source bit of output bit k+1
    localparam int c_IP_TABLE [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int c_FP_TABLE [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

`default_nettype wire

// File: rtl/initial_perm.sv
// =============================================================================
// initial_perm : combinational DES initial permutation IP
// Revision: 1.0
// =============================================================================
`default_nettype none

module initial_perm
    import des_pkg::*;
(
    input  logic [63:0] data_in,
    output logic [63:0] out
);

    for (genvar k = 0; k < 64; k++) begin : g_bit
        assign out[63-k] = data_in[64 - c_IP_TABLE[k]];
    end

endmodule

`default_nettype wire

// File: rtl/des_init_perm_stage.sv
// =============================================================================
// des_init_perm_stage : IP on input, 2-entry FIFO of permuted blocks, block count
// Revision: 1.0
// =============================================================================
`default_nettype none

module des_init_perm_stage
    import des_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_l,
    output logic [31:0]      out_r,
    output logic [CNT_W-1:0] blk_cnt
);

    occ_e             occ_q, occ_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [63:0]      mem_q [c_FIFO_DEPTH];
    logic [63:0]      hold_q;
    logic [CNT_W-1:0] blk_cnt_q;

    logic [63:0]      w_perm;
    logic [63:0]      w_head;
    logic             w_accept;
    logic             w_pop;

    initial_perm u_initial_perm (
        .data_in (data_in),
        .out     (w_perm)
    );

    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = mem_q[rd_ptr_q];

    // hold_q keeps the last presented block visible once the FIFO drains
    assign {out_l, out_r} = out_valid ? w_head : hold_q;
    assign blk_cnt        = blk_cnt_q;

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            occ_d    = OCC_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (w_accept) wr_ptr_d = ~wr_ptr_q;
            if (w_pop)    rd_ptr_d = ~rd_ptr_q;
            case (occ_q)
                OCC_EMPTY: if (w_accept) occ_d = OCC_ONE;
                OCC_ONE: begin
                    if (w_accept && !w_pop)      occ_d = OCC_FULL;
                    else if (!w_accept && w_pop) occ_d = OCC_EMPTY;
                end
                OCC_FULL:  if (w_pop) occ_d = OCC_ONE;
                default:   occ_d = OCC_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q     <= OCC_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            blk_cnt_q <= '0;
            hold_q    <= '0;
            for (int i = 0; i < c_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // a block accepted during flush is counted but never stored
            if (w_accept && !flush) mem_q[wr_ptr_q] <= w_perm;
            if (w_accept)           blk_cnt_q <= blk_cnt_q + 1'b1;
            if (out_valid)          hold_q <= w_head;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_des_init_perm_stage.sv
// =============================================================================
// tb_des_init_perm_stage : directed checks of the DES IP stage
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_des_init_perm_stage;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] data_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_l, out_r;
    logic [15:0] blk_cnt;

    logic        s_flush = 1'b0;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [63:0] s_data_in = '0;
    logic        s_out_valid;
    logic        s_out_ready = 1'b1;
    logic [31:0] s_out_l, s_out_r;
    logic [3:0]  s_blk_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_init_perm_stage u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_l(out_l), .out_r(out_r), .blk_cnt(blk_cnt)
    );

    des_init_perm_stage #(.CNT_W(4)) u_dut_small (
        .clk(clk), .rst(rst), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .data_in(s_data_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_l(s_out_l), .out_r(s_out_r), .blk_cnt(s_blk_cnt)
    );

    function automatic logic [63:0] final_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[63-k] = x[64 - c_FP_TABLE[k]];
        return y;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (blk_cnt !== 16'd0) begin n_err++; $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); end
        n_vec++; if ({out_l, out_r} !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", {out_l, out_r}); end
    endtask

    task automatic test_known_answer();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h0123456789ABCDEF;
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL kat_out_valid got %b want 1", out_valid); end
        n_vec++; if (out_l !== 32'hCC00CCFF) begin n_err++; $display("FAIL kat_out_l got %h want cc00ccff", out_l); end
        n_vec++; if (out_r !== 32'hF0AAF0AA) begin n_err++; $display("FAIL kat_out_r got %h want f0aaf0aa", out_r); end
        n_vec++; if (blk_cnt !== 16'd1) begin n_err++; $display("FAIL kat_blk_cnt got %0d want 1", blk_cnt); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL kat_drain_valid got %b want 0", out_valid); end
        n_vec++; if ({out_l, out_r} !== 64'hCC00CCFF_F0AAF0AA) begin n_err++; $display("FAIL kat_hold got %h want cc00ccfff0aaf0aa", {out_l, out_r}); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h0;
        step();
        data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        data_in = 64'h0123456789ABCDEF;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_vec++; if ({out_l, out_r} !== 64'h0) begin n_err++; $display("FAIL bp_head0 got %h want 0", {out_l, out_r}); end
        step();
        in_valid = 1'b0;
        n_vec++; if (blk_cnt !== 16'd3) begin n_err++; $display("FAIL bp_blk_cnt got %0d want 3", blk_cnt); end
        n_vec++; if (out_valid !== 1'b1 || {out_l, out_r} !== 64'h0) begin n_err++; $display("FAIL bp_hold got v=%b %h want v=1 0", out_valid, {out_l, out_r}); end
        out_ready = 1'b1;
        step();
        n_vec++; if (out_valid !== 1'b1 || out_l !== 32'hFFFFFFFF || out_r !== 32'hFFFFFFFF) begin n_err++; $display("FAIL bp_second got v=%b %h/%h want v=1 ffffffff/ffffffff", out_valid, out_l, out_r); end
        step();
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_streaming();
        logic [63:0] q[$];
        logic [63:0] blk, exp_blk;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        blk = {$urandom, $urandom};
        data_in = blk;
        q.push_back(blk);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (i < 100) begin
                blk = {$urandom, $urandom};
                data_in = blk;
            end else begin
                in_valid = 1'b0;
            end
            n_vec++;
            if (out_valid !== 1'b1 || (i < 100 && in_ready !== 1'b1)) begin
                n_err++; $display("FAIL stream_occ cycle %0d got v=%b r=%b want v=1 r=1", i, out_valid, in_ready);
            end
            exp_blk = q.pop_front();
            n_vec++;
            if (final_perm({out_l, out_r}) !== exp_blk) begin
                n_err++; $display("FAIL stream_data cycle %0d got %h want %h", i, final_perm({out_l, out_r}), exp_blk);
            end
            if (i < 100) q.push_back(blk);
            step();
        end
        out_ready = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
        n_vec++; if (blk_cnt !== 16'd103) begin n_err++; $display("FAIL stream_blk_cnt got %0d want 103", blk_cnt); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h1111_2222_3333_4444;
        step();
        data_in = 64'h5555_6666_7777_8888;
        step();
        flush = 1'b1;
        data_in = 64'h0123456789ABCDEF;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL flush_full got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_vec++; if (blk_cnt !== 16'd105) begin n_err++; $display("FAIL flush_full_cnt got %0d want 105", blk_cnt); end
        in_valid = 1'b1;
        data_in  = 64'hAAAA_AAAA_AAAA_AAAA;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || blk_cnt !== 16'd107) begin n_err++; $display("FAIL flush_one got v=%b cnt=%0d want v=0 cnt=107", out_valid, blk_cnt); end
        in_valid = 1'b1;
        data_in  = 64'h0123456789ABCDEF;
        step();
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1 || {out_l, out_r} !== 64'hCC00CCFF_F0AAF0AA) begin n_err++; $display("FAIL flush_after got v=%b %h want v=1 cc00ccfff0aaf0aa", out_valid, {out_l, out_r}); end
    endtask

    task automatic test_rst_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 64'h0123456789ABCDEF;
        step();
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_pre_full got %b want 0", in_ready); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_hs got v=%b r=%b want v=0 r=1", out_valid, in_ready); end
        n_vec++; if (blk_cnt !== 16'd0) begin n_err++; $display("FAIL rst_mid_cnt got %0d want 0", blk_cnt); end
        n_vec++; if (out_l !== 32'h0 || out_r !== 32'h0) begin n_err++; $display("FAIL rst_mid_data got %h/%h want 0/0", out_l, out_r); end
    endtask

    task automatic test_cnt_wrap();
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            s_data_in = 64'(i);
            step();
            if (i == 15) begin
                n_vec++; if (s_blk_cnt !== 4'd15) begin n_err++; $display("FAIL wrap_15 got %0d want 15", s_blk_cnt); end
            end
            if (i == 16) begin
                n_vec++; if (s_blk_cnt !== 4'd0) begin n_err++; $display("FAIL wrap_16 got %0d want 0", s_blk_cnt); end
            end
        end
        s_in_valid = 1'b0;
        n_vec++; if (s_blk_cnt !== 4'd1) begin n_err++; $display("FAIL wrap_17 got %0d want 1", s_blk_cnt); end
    endtask

    initial begin
        test_reset();
        test_known_answer();
        test_backpressure();
        test_streaming();
        test_flush();
        test_rst_midstream();
        test_cnt_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
